// File: rtl/procyon_lsu_ex_cdbq.sv
// LSU execute stage: load extraction, CDB result queue and LQ/SQ updates.
// Also forwards dirty fill victims toward the writeback path.
package procyon_lsu_pkg;
    localparam int PCYN_OP_WIDTH      = 5;
    localparam int PCYN_OP_IS_WIDTH   = 4;
    localparam int PCYN_OP_IS_ST_IDX  = 2;
    localparam logic [PCYN_OP_WIDTH-1:0] PCYN_OP_LB   = 5'd0;
    localparam logic [PCYN_OP_WIDTH-1:0] PCYN_OP_LH   = 5'd1;
    localparam logic [PCYN_OP_WIDTH-1:0] PCYN_OP_LW   = 5'd2;
    localparam logic [PCYN_OP_WIDTH-1:0] PCYN_OP_LBU  = 5'd3;
    localparam logic [PCYN_OP_WIDTH-1:0] PCYN_OP_LHU  = 5'd4;
    localparam logic [PCYN_OP_WIDTH-1:0] PCYN_OP_SB   = 5'd5;
    localparam logic [PCYN_OP_WIDTH-1:0] PCYN_OP_SH   = 5'd6;
    localparam logic [PCYN_OP_WIDTH-1:0] PCYN_OP_SW   = 5'd7;
    localparam logic [PCYN_OP_WIDTH-1:0] PCYN_OP_FILL = 5'd8;
endpackage

module procyon_lsu_ex_cdbq
    import procyon_lsu_pkg::*;
#(
    parameter int OPTN_DATA_WIDTH    = 32,
    parameter int OPTN_ADDR_WIDTH    = 32,
    parameter int OPTN_LQ_DEPTH      = 8,
    parameter int OPTN_SQ_DEPTH      = 8,
    parameter int OPTN_DC_LINE_SIZE  = 32,
    parameter int OPTN_ROB_IDX_WIDTH = 5,
    parameter int OPTN_CDBQ_DEPTH    = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_flush,
    input  logic                               i_valid,
    input  logic                               i_fill_replay,
    input  logic                               i_retire,
    input  logic [PCYN_OP_WIDTH-1:0]           i_op,
    input  logic [PCYN_OP_IS_WIDTH-1:0]        i_op_is,
    input  logic [$clog2(OPTN_DATA_WIDTH/8)-1:0] i_byte_offset,
    input  logic [OPTN_LQ_DEPTH-1:0]           i_lq_select,
    input  logic [OPTN_SQ_DEPTH-1:0]           i_sq_select,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0]      i_tag,
    input  logic                               i_dc_hit,
    input  logic [OPTN_DATA_WIDTH-1:0]         i_dc_data,
    input  logic                               i_dc_victim_valid,
    input  logic                               i_dc_victim_dirty,
    input  logic [OPTN_ADDR_WIDTH-1:0]         i_dc_victim_addr,
    input  logic [8*OPTN_DC_LINE_SIZE-1:0]     i_dc_victim_data,
    input  logic                               i_cdb_grant,
    output logic                               o_cdb_valid,
    output logic [OPTN_DATA_WIDTH-1:0]         o_cdb_data,
    output logic [OPTN_ROB_IDX_WIDTH-1:0]      o_cdb_tag,
    output logic                               o_stall,
    output logic                               o_update_lq_en,
    output logic [OPTN_LQ_DEPTH-1:0]           o_update_lq_select,
    output logic                               o_update_sq_en,
    output logic [OPTN_SQ_DEPTH-1:0]           o_update_sq_select,
    output logic                               o_update_retry,
    output logic                               o_update_replay,
    output logic                               o_victim_en,
    output logic [OPTN_ADDR_WIDTH-1:0]         o_victim_addr,
    output logic [8*OPTN_DC_LINE_SIZE-1:0]     o_victim_data
);
    localparam int DW    = OPTN_DATA_WIDTH;
    localparam int PTR_W = $clog2(OPTN_CDBQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DW-1:0]                 cdbq_data_q [OPTN_CDBQ_DEPTH];
    logic [OPTN_ROB_IDX_WIDTH-1:0] cdbq_tag_q  [OPTN_CDBQ_DEPTH];
    logic [CNT_W-1:0]              count_q, count_d;
    logic [PTR_W-1:0]              head_q, head_d;
    logic [PTR_W-1:0]              tail_q, tail_d;

    logic lq_en_q, lq_en_d;
    logic sq_en_q, sq_en_d;
    logic retry_q, retry_d;
    logic replay_q, replay_d;
    logic victim_en_q, victim_en_d;
    logic [OPTN_LQ_DEPTH-1:0]          lq_select_q;
    logic [OPTN_SQ_DEPTH-1:0]          sq_select_q;
    logic [OPTN_ADDR_WIDTH-1:0]        victim_addr_q;
    logic [8*OPTN_DC_LINE_SIZE-1:0]    victim_data_q;

    logic          fill, store, result;
    logic          full, empty, push, pop, overflow, sq_take;
    logic [DW-1:0] shifted, ld_data, push_data;

    assign fill     = (i_op == PCYN_OP_FILL);
    assign store    = i_op_is[PCYN_OP_IS_ST_IDX];
    assign result   = ~i_flush & i_valid & ~fill & ~i_retire
                    & (i_dc_hit | store);
    assign full     = (count_q == CNT_W'(OPTN_CDBQ_DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = i_cdb_grant & ~empty;
    assign push     = result & (~full | pop);
    assign overflow = result & full & ~pop;
    assign sq_take  = ~i_flush & i_valid
                    & (i_retire | (store & overflow));

    always_comb begin
        shifted = i_dc_data >> {i_byte_offset, 3'b000};
        ld_data = shifted;
        case (i_op)
            PCYN_OP_LB:  ld_data = {{(DW-8){shifted[7]}}, shifted[7:0]};
            PCYN_OP_LH:  ld_data = {{(DW-16){shifted[15]}}, shifted[15:0]};
            PCYN_OP_LBU: ld_data = {{(DW-8){1'b0}}, shifted[7:0]};
            PCYN_OP_LHU: ld_data = {{(DW-16){1'b0}}, shifted[15:0]};
            default:     ld_data = shifted;
        endcase
        // Stores forward the raw word; alignment is handled downstream
        push_data = store ? i_dc_data : ld_data;
    end

    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
        lq_en_d     = ~i_flush & i_valid & ~fill & ~store;
        sq_en_d     = sq_take;
        retry_d     = (sq_take & ~overflow) ? 1'b0
                    : (~i_dc_hit | overflow);
        replay_d    = i_fill_replay;
        victim_en_d = i_valid & fill & i_dc_victim_valid
                    & i_dc_victim_dirty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            lq_en_q     <= 1'b0;
            sq_en_q     <= 1'b0;
            retry_q     <= 1'b0;
            replay_q    <= 1'b0;
            victim_en_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            lq_en_q     <= lq_en_d;
            sq_en_q     <= sq_en_d;
            retry_q     <= retry_d;
            replay_q    <= replay_d;
            victim_en_q <= victim_en_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            cdbq_data_q[tail_q] <= push_data;
            cdbq_tag_q[tail_q]  <= i_tag;
        end
        lq_select_q   <= i_lq_select;
        sq_select_q   <= i_sq_select;
        victim_addr_q <= i_dc_victim_addr;
        victim_data_q <= i_dc_victim_data;
    end

    assign o_cdb_valid        = ~empty;
    assign o_cdb_data         = cdbq_data_q[head_q];
    assign o_cdb_tag          = cdbq_tag_q[head_q];
    assign o_stall            = (count_q >= CNT_W'(OPTN_CDBQ_DEPTH - 1));
    assign o_update_lq_en     = lq_en_q;
    assign o_update_lq_select = lq_select_q;
    assign o_update_sq_en     = sq_en_q;
    assign o_update_sq_select = sq_select_q;
    assign o_update_retry     = retry_q;
    assign o_update_replay    = replay_q;
    assign o_victim_en        = victim_en_q;
    assign o_victim_addr      = victim_addr_q;
    assign o_victim_data      = victim_data_q;

endmodule
